// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - arbiter-PUF evaluation controller with majority-vote response collection
module puf_eval_ctrl #(
    parameter int CH_W      = 8,
    parameter int RESP_BITS = 16,
    parameter int SETTLE    = 4,
    parameter int VOTES     = 5
) (
    input  logic                 c,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_W-1:0]      seed,
    output logic [CH_W-1:0]      chal,
    output logic                 launch,
    input  logic                 puf_q,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int VW = $clog2(VOTES + 1);
    localparam int KW = $clog2(RESP_BITS + 1);
    localparam int WW = $clog2(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_WAIT,
        S_SAMPLE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CH_W-1:0] seed_r;
    logic [KW-1:0]   k;
    logic [VW-1:0]   votes;
    logic [VW-1:0]   ones;
    logic [WW-1:0]   wcnt;
    logic            sync1;
    logic            puf_s;

    // Challenge for bit k is seed + k; it only moves in NEXT, so it is stable across every vote of a bit.
    assign chal = seed_r + CH_W'(k);

    // State register
    always_ff @(posedge c) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: SETUP/LAUNCH/WAIT/SAMPLE repeat per vote, NEXT closes out a bit
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (wcnt == WW'(SETTLE - 1)) state_nx = S_SAMPLE;
            S_SAMPLE: state_nx = (votes == VW'(VOTES - 1)) ? S_NEXT : S_SETUP;
            S_NEXT:   state_nx = (k == KW'(RESP_BITS - 1)) ? S_DONE : S_SETUP;
            S_DONE:   if (resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state alone
    always_comb begin
        launch     = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            S_IDLE:   busy = 1'b0;
            S_LAUNCH: launch = 1'b1;
            S_DONE: begin
                busy       = 1'b0;
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Synchronizer, vote counters, settle timer and response accumulation
    always_ff @(posedge c) begin
        if (rst) begin
            sync1  <= 1'b0;
            puf_s  <= 1'b0;
            seed_r <= '0;
            k      <= '0;
            votes  <= '0;
            ones   <= '0;
            wcnt   <= '0;
            resp   <= '0;
        end else begin
            sync1 <= puf_q;
            puf_s <= sync1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_r <= seed;
                        k      <= '0;
                        votes  <= '0;
                        ones   <= '0;
                        resp   <= '0;
                    end
                end
                S_LAUNCH: wcnt <= '0;
                S_WAIT: begin
                    if (wcnt != WW'(SETTLE - 1)) wcnt <= wcnt + WW'(1);
                end
                S_SAMPLE: begin
                    ones  <= ones + VW'(puf_s);
                    votes <= votes + VW'(1);
                end
                S_NEXT: begin
                    for (int i = 0; i < RESP_BITS; i++) begin
                        if (k == KW'(i)) resp[i] <= (ones > VW'(VOTES / 2));
                    end
                    votes <= '0;
                    ones  <= '0;
                    k     <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - scoreboard bench for puf_eval_ctrl
module tb_puf_eval_ctrl;

    localparam int LAT = 577;

    logic        c = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  seed;
    logic [7:0]  chal;
    logic        launch;
    logic        puf_q;
    logic [15:0] resp;
    logic        resp_valid;
    logic        resp_ready;
    logic        busy;

    typedef struct {
        logic [15:0] resp;
        int          start_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lcnt = 0;
    int          lbase = 0;
    logic [1:0]  pmode;
    logic [4:0]  pat;
    logic        chk_chal;
    logic [7:0]  chk_seed;
    logic        vprev = 1'b0;

    puf_eval_ctrl dut (
        .c          (c),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .chal       (chal),
        .launch     (launch),
        .puf_q      (puf_q),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 c = ~c;

    always @(posedge c) cyc++;

    // PUF model: constant 1, follows chal[0], or a per-vote pattern for the first bit only
    always_comb begin
        case (pmode)
            2'd0:    puf_q = 1'b1;
            2'd1:    puf_q = chal[0];
            2'd2:    puf_q = ((lcnt - lbase) >= 1 && (lcnt - lbase) <= 5) ? pat[lcnt - lbase - 1] : 1'b0;
            default: puf_q = 1'b0;
        endcase
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts launches, checks the challenge sequence and pops the scoreboard when resp_valid rises
    always @(negedge c) begin
        exp_t e;
        if (rst) begin
            vprev = 1'b0;
        end else begin
            if (launch) begin
                lcnt++;
                if (chk_chal)
                    check(chal == 8'(chk_seed + 8'((lcnt - lbase - 1) / 5)), "chal_seq",
                          32'(chal), 32'(8'(chk_seed + 8'((lcnt - lbase - 1) / 5))));
            end
            if (resp_valid && !vprev) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_resp_valid", 32'(resp), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check(resp == e.resp, "resp", 32'(resp), 32'(e.resp));
                    check((cyc - e.start_cyc) == LAT, "latency", 32'(cyc - e.start_cyc), 32'(LAT));
                end
            end
            vprev = resp_valid;
        end
    end

    task automatic issue(input logic [7:0] s, input logic [1:0] pm, input logic [15:0] exp);
        @(negedge c);
        pmode = pm;
        lbase = lcnt;
        seed  = s;
        start = 1'b1;
        sb_q.push_back('{resp: exp, start_cyc: cyc});
        @(negedge c);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge c);
        end
        if (!seen) check(1'b0, "resp_valid_timeout", 32'(resp_valid), 32'h1);
    endtask

    task automatic run(input logic [7:0] s, input logic [1:0] pm, input logic [15:0] exp);
        issue(s, pm, exp);
        wait_valid();
        @(negedge c);
        check(!resp_valid && !busy, "idle_after_accept", {30'h0, resp_valid, busy}, 32'h0);
    endtask

    initial begin
        bit hit;
        rst        = 1'b1;
        start      = 1'b0;
        seed       = 8'h00;
        resp_ready = 1'b1;
        pmode      = 2'd0;
        pat        = 5'b0;
        chk_chal   = 1'b0;
        chk_seed   = 8'h00;
        repeat (3) @(negedge c);
        check(busy == 1'b0, "reset_busy", 32'(busy), 32'h0);
        check(resp_valid == 1'b0, "reset_resp_valid", 32'(resp_valid), 32'h0);
        check(launch == 1'b0, "reset_launch", 32'(launch), 32'h0);
        check(chal == 8'h00, "reset_chal", 32'(chal), 32'h0);
        check(resp == 16'h0000, "reset_resp", 32'(resp), 32'h0);
        rst = 1'b0;

        // all-ones PUF: every bit votes 1, one launch per vote
        run(8'h00, 2'd0, 16'hFFFF);
        check((lcnt - lbase) == 80, "launch_count", 32'(lcnt - lbase), 32'd80);

        // PUF follows chal[0]
        run(8'h00, 2'd1, 16'hAAAA);
        run(8'h01, 2'd1, 16'h5555);

        // majority vote on bit 0: 3 of 5 then 2 of 5
        pat = 5'b10011;
        run(8'h00, 2'd2, 16'h0001);
        pat = 5'b01001;
        run(8'h00, 2'd2, 16'h0000);

        // challenge wrap-around from 0xFF
        chk_seed = 8'hFF;
        chk_chal = 1'b1;
        run(8'hFF, 2'd1, 16'h5555);
        chk_chal = 1'b0;

        // start ignored while busy, DONE held by resp_ready=0
        resp_ready = 1'b0;
        issue(8'h00, 2'd1, 16'hAAAA);
        repeat (50) @(negedge c);
        seed  = 8'h01;
        start = 1'b1;
        @(negedge c);
        start = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge c);
            check(resp_valid && !busy, "done_hold_valid", {30'h0, resp_valid, busy}, 32'h2);
            check(resp == 16'hAAAA, "done_hold_resp", 32'(resp), 32'hAAAA);
        end
        resp_ready = 1'b1;
        @(negedge c);
        check(!resp_valid && !busy, "idle_after_hold", {30'h0, resp_valid, busy}, 32'h0);
        check(resp == 16'hAAAA, "idle_resp_hold", 32'(resp), 32'hAAAA);
        repeat (5) @(negedge c);
        check(busy == 1'b0, "no_restart", 32'(busy), 32'h0);

        // reset abandons an evaluation during WAIT of bit 7
        issue(8'h00, 2'd1, 16'hAAAA);
        hit = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ((lcnt - lbase) == 36) begin
                hit = 1'b1;
                break;
            end
            @(negedge c);
        end
        if (!hit) check(1'b0, "bit7_launch_timeout", 32'(lcnt - lbase), 32'd36);
        @(negedge c);
        rst = 1'b1;
        @(negedge c);
        rst = 1'b0;
        sb_q.delete();
        check(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
        check(launch == 1'b0, "rst_launch", 32'(launch), 32'h0);
        check(resp == 16'h0000, "rst_resp", 32'(resp), 32'h0);
        check(resp_valid == 1'b0, "rst_resp_valid", 32'(resp_valid), 32'h0);
        check(chal == 8'h00, "rst_chal", 32'(chal), 32'h0);
        run(8'h00, 2'd1, 16'hAAAA);

        check(sb_q.size() == 0, "scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
